multicycle_control: RTL
=======================

# multicycle_control

Moore-style control FSM for the multicycle CPU datapath. It consumes the 6-bit opcode (CtrlOp) latched in the datapath's instruction register and drives every datapath control strobe and mux select, one state per cycle. It also exposes halt/illegal status and a retired-instruction counter for the bench.

## Interface
- COUNT_WIDTH, 16, width of retired-instruction counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- CtrlOp  in  6  opcode from instruction register
- PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite, MemtoReg, ReadDst, BranchSel  out  1 (PCWriteCond 2, driven {1'b0,cond})  datapath strobes/selects
- ALUSrcA  out  2  00 PC, 01 A, 10 zero
- ALUSrcB  out  2  00 B, 01 sign-ext imm, 10 zero-ext imm, 11 constant 1
- PCSource  out  2  00 ALUResult, 01 ALUOut, 10 jump target
- ALUOp  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- state  out  4  current state code (debug)
- halted  out  1  high while in HALT
- illegal  out  1  sticky: undefined opcode decoded
- instr_count  out  COUNT_WIDTH  instructions retired, wraps

## Operation
- Opcodes: 00 ADD, 01 SUB, 02 AND, 03 OR, 04 XOR, 05 SLT (R-type, ReadDst=1); 08 ADDI (SE), 0A ANDI (ZE), 0B ORI (ZE); 10 LW; 11 SW; 12 BEQ; 13 BNE; 14 J; 3F HALT. All others illegal.
- States (code): INIT 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, ALU_WB 5, MEM_ADDR 6, MEM_RD 7, MEM_WB 8, MEM_WR 9, BRANCH 10, JUMP 11, HALT 12.
- Every output not listed for a state is 0. MemtoReg: 0 = MDR, 1 = ALUOut. BranchSel: 1 = BEQ (zero), 0 = BNE.
- INIT: all outputs 0; -> FETCH.
- FETCH: IRWrite=1, ALUSrcA=00, ALUSrcB=11, ALUOp=add, PCSource=00, PCWrite=1; -> DECODE.
- DECODE: ALUSrcA=00, ALUSrcB=01, ALUOp=add (ALUOut <= PC+1+SE imm branch target); ReadDst=1 for R-type opcodes, else 0. Next: R-type -> EXEC_R; ADDI/ANDI/ORI -> EXEC_I; LW/SW -> MEM_ADDR; BEQ/BNE -> BRANCH; J -> JUMP; HALT -> HALT; illegal -> set illegal, -> FETCH (treated as NOP, retired).
- EXEC_R: ALUSrcA=01, ALUSrcB=00, ALUOp per opcode; -> ALU_WB.
- EXEC_I: ALUSrcA=01, ALUSrcB=01 (ADDI) or 10 (ANDI/ORI), ALUOp add/and/or; -> ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=1; -> FETCH.
- MEM_ADDR: ALUSrcB=01, ALUOp=add, ALUSrcA=01 for LW, 10 for SW; LW -> MEM_RD, SW -> MEM_WR.
- MEM_RD: MemRead=1; -> MEM_WB. MEM_WB: RegWrite=1, MemtoReg=0; -> FETCH.
- MEM_WR: MemWrite=1; -> FETCH.
- BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=sub, PCSource=01, PCWriteCond=01, BranchSel=1 for BEQ / 0 for BNE; -> FETCH.
- JUMP: PCSource=10, PCWrite=1; -> FETCH.
- HALT: all strobes 0, halted=1; stays until reset.
- instr_count increments by 1 on every transition into FETCH from a non-INIT state; wraps all-ones -> 0.

## Timing
- All control outputs are pure decode of the state register (and CtrlOp in DECODE/EXEC/MEM/BRANCH states); no combinational path from datapath status.
- CPI: R/I-type 4, LW 5, SW 4, branch 3, J 3, illegal 2.
- reset low (any time, including mid-instruction): state=INIT immediately, all outputs 0, illegal=0, instr_count=0. First FETCH occurs the second rising edge after reset deasserts... precisely: edge 1 INIT->FETCH, PC updated on edge 2.
- CtrlOp is sampled only from DECODE onward; IR changes only on FETCH edges, so CtrlOp is stable for the rest of the instruction.

## Test plan
- Reset release, opcode don't-care -> cycle 0 state=0 all outputs 0; cycle 1 state=1, IRWrite=PCWrite=1, ALUSrcB=11; instr_count=0.
- CtrlOp=00 (ADD) -> states 1,2,3,5,1; EXEC_R ALUOp=000 ALUSrcA=01; ALU_WB RegWrite=1 MemtoReg=1; instr_count=1.
- CtrlOp=10 (LW) then 11 (SW) -> LW 1,2,6,7,8 with MemRead in 7, RegWrite/MemtoReg=0 in 8; SW MEM_ADDR ALUSrcA=10, MemWrite=1 in 9; count=2.
- CtrlOp=13 (BNE) -> 1,2,10,1 with PCWriteCond=01, BranchSel=0, ALUOp=001, PCSource=01; CtrlOp=14 -> JUMP PCSource=10 PCWrite=1.
- CtrlOp=2A -> illegal=1 after DECODE, returns to FETCH, count increments; illegal stays 1 through a later valid ADD.
- CtrlOp=3F -> HALT, halted=1 indefinitely, count frozen; pull reset low mid-EXEC_R of a later run -> immediate state=0, count=0.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for the multicycle CPU datapath
module multicycle_control #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             CtrlOp,
  output logic                   PCWrite,
  output logic [1:0]             PCWriteCond,
  output logic                   IRWrite,
  output logic                   RegWrite,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   MemtoReg,
  output logic                   ReadDst,
  output logic                   BranchSel,
  output logic [1:0]             ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             PCSource,
  output logic [2:0]             ALUOp,
  output logic [3:0]             state,
  output logic                   halted,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0A;
  localparam logic [5:0] OP_ORI  = 6'h0B;
  localparam logic [5:0] OP_LW   = 6'h10;
  localparam logic [5:0] OP_SW   = 6'h11;
  localparam logic [5:0] OP_BEQ  = 6'h12;
  localparam logic [5:0] OP_BNE  = 6'h13;
  localparam logic [5:0] OP_J    = 6'h14;
  localparam logic [5:0] OP_HALT = 6'h3F;

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_illegal;
  logic [COUNT_WIDTH-1:0] r_count;

  logic w_rtype, w_itype, w_mem, w_branch;

  // R-type opcodes 00..05 map their low bits directly onto the ALUOp encoding
  assign w_rtype  = (CtrlOp <= 6'h05);
  assign w_itype  = (CtrlOp == OP_ADDI) || (CtrlOp == OP_ANDI) || (CtrlOp == OP_ORI);
  assign w_mem    = (CtrlOp == OP_LW) || (CtrlOp == OP_SW);
  assign w_branch = (CtrlOp == OP_BEQ) || (CtrlOp == OP_BNE);

  // Next-state selection; CtrlOp is only consulted from DECODE onward
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:     w_next = S_FETCH;
      S_FETCH:    w_next = S_DECODE;
      S_DECODE: begin
        if (w_rtype)                 w_next = S_EXEC_R;
        else if (w_itype)            w_next = S_EXEC_I;
        else if (w_mem)              w_next = S_MEM_ADDR;
        else if (w_branch)           w_next = S_BRANCH;
        else if (CtrlOp == OP_J)     w_next = S_JUMP;
        else if (CtrlOp == OP_HALT)  w_next = S_HALT;
        else                         w_next = S_FETCH;
      end
      S_EXEC_R:   w_next = S_ALU_WB;
      S_EXEC_I:   w_next = S_ALU_WB;
      S_ALU_WB:   w_next = S_FETCH;
      S_MEM_ADDR: w_next = (CtrlOp == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next = S_MEM_WB;
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_INIT;
    endcase
  end

  // State, sticky illegal flag and retired count; an undecodable opcode retires as a NOP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_INIT;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE && !w_rtype && !w_itype && !w_mem && !w_branch &&
          CtrlOp != OP_J && CtrlOp != OP_HALT)
        r_illegal <= 1'b1;
      if (w_next == S_FETCH && r_state != S_INIT)
        r_count <= r_count + COUNT_WIDTH'(1);
    end
  end

  // Moore decode of the control strobes; everything not named for a state stays 0
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 2'b00;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    ReadDst     = 1'b0;
    BranchSel   = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 3'b000;
    case (r_state)
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b11;
      end
      S_DECODE: begin
        ALUSrcB = 2'b01;
        ReadDst = w_rtype;
      end
      S_EXEC_R: begin
        ALUSrcA = 2'b01;
        ALUOp   = CtrlOp[2:0];
      end
      S_EXEC_I: begin
        ALUSrcA = 2'b01;
        if (CtrlOp == OP_ADDI) begin
          ALUSrcB = 2'b01;
          ALUOp   = 3'b000;
        end else begin
          ALUSrcB = 2'b10;
          ALUOp   = (CtrlOp == OP_ANDI) ? 3'b010 : 3'b011;
        end
      end
      S_ALU_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_ADDR: begin
        ALUSrcB = 2'b01;
        ALUSrcA = (CtrlOp == OP_SW) ? 2'b10 : 2'b01;
      end
      S_MEM_RD:  MemRead = 1'b1;
      S_MEM_WB:  RegWrite = 1'b1;
      S_MEM_WR:  MemWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 2'b01;
        ALUOp       = 3'b001;
        PCSource    = 2'b01;
        PCWriteCond = 2'b01;
        BranchSel   = (CtrlOp == OP_BEQ);
      end
      S_JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state       = r_state;
  assign halted      = (r_state == S_HALT);
  assign illegal     = r_illegal;
  assign instr_count = r_count;

endmodule
